data_mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of data_mem. The 16-bit data memory has single-cycle write strobes and registered read data.
- Requester 0 is the CPU load/store stage; requester 1 is the loader/debug port.
- Round-robin arbitration on contention, then one memory transaction per grant.
- Drives data_mem's MemWrite, MemRead, address and write data; captures read data; returns a one-cycle done pulse to the winning requester.

---
 rtl/data_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-requester round-robin arbiter and sequencer for a 16-bit data
// memory with single-cycle write strobes and registered read data.
// Requester 0 is the CPU load/store stage; requester 1 is the loader/debug port.
// Optional grant/contention statistics counters are compiled in with `define ARB_STATS_EN.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_grant0,
  output logic [15:0]       stat_grant1,
  output logic [15:0]       stat_contend
`endif
);

  localparam logic [2:0] LatInit = 3'(READ_LATENCY);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e              r_state;
  logic                r_last_grant;  // 1 = requester 1 was granted last
  logic                r_grant;       // requester owning the current transaction
  logic                r_op_we;
  logic [2:0]          r_cnt;
  logic                r_mem_write;
  logic                r_mem_read;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_done0;
  logic                r_done1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_idle;
  logic                w_any_req;
  logic                w_both_req;
  logic                w_win1;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  assign w_idle      = (r_state == StIdle);
  assign w_any_req   = r0_req | r1_req;
  assign w_both_req  = r0_req & r1_req;
  // On contention the requester that did not win last time gets the grant.
  assign w_win1      = r1_req & (~r0_req | ~r_last_grant);
  assign w_sel_we    = w_win1 ? r1_we    : r0_we;
  assign w_sel_addr  = w_win1 ? r1_addr  : r0_addr;
  assign w_sel_wdata = w_win1 ? r1_wdata : r0_wdata;

  // Arbitration FSM with registered strobes, done pulses and read-data capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_op_we      <= 1'b0;
      r_cnt        <= 3'd0;
      r_mem_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      // Strobes and done are single-cycle pulses unless set below.
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_grant      <= w_win1;
            r_last_grant <= w_win1;
            r_op_we      <= w_sel_we;
            r_mem_addr   <= w_sel_addr;
            r_mem_wdata  <= w_sel_wdata;
            r_mem_write  <= w_sel_we;
            r_mem_read   <= ~w_sel_we;
            r_state      <= StIssue;
          end
        end
        StIssue: begin
          if (r_op_we) begin
            r_done0 <= ~r_grant;
            r_done1 <= r_grant;
            r_state <= StResp;
          end else begin
            r_cnt   <= LatInit;
            r_state <= StWait;
          end
        end
        StWait: begin
          r_cnt <= r_cnt - 3'd1;
          // Counter reaches zero on this edge: read data is valid now.
          if (r_cnt == 3'd1) begin
            if (r_grant) r_rdata1 <= mem_rdata;
            else         r_rdata0 <= mem_rdata;
            r_done0 <= ~r_grant;
            r_done1 <= r_grant;
            r_state <= StResp;
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign mem_write = r_mem_write;
  assign mem_read  = r_mem_read;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign r0_done   = r_done0;
  assign r1_done   = r_done1;
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;
  assign busy      = ~w_idle;

`ifdef ARB_STATS_EN
  logic [15:0] r_stat_grant0;
  logic [15:0] r_stat_grant1;
  logic [15:0] r_stat_contend;

  // Saturating grant/contention counters; clear has priority over increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_grant0  <= '0;
      r_stat_grant1  <= '0;
      r_stat_contend <= '0;
    end else if (stat_clr) begin
      r_stat_grant0  <= '0;
      r_stat_grant1  <= '0;
      r_stat_contend <= '0;
    end else if (w_idle) begin
      if (w_any_req && !w_win1 && (r_stat_grant0 != 16'hFFFF)) begin
        r_stat_grant0 <= r_stat_grant0 + 16'd1;
      end
      if (w_win1 && (r_stat_grant1 != 16'hFFFF)) begin
        r_stat_grant1 <= r_stat_grant1 + 16'd1;
      end
      if (w_both_req && (r_stat_contend != 16'hFFFF)) begin
        r_stat_contend <= r_stat_contend + 16'd1;
      end
    end
  end

  assign stat_grant0  = r_stat_grant0;
  assign stat_grant1  = r_stat_grant1;
  assign stat_contend = r_stat_contend;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: a transaction-level reference model predicts,
// per clock edge, which requester is granted, when its done pulse appears and what read
// data it returns; DUT outputs are compared on every falling edge.
module tb_data_mem_arbiter;
  localparam int unsigned L = 1;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [15:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_done, r1_done;
  logic [15:0] r0_rdata, r1_rdata;
  logic        mem_write, mem_read, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_grant0, stat_grant1, stat_contend;
`endif

  always #5 clock = ~clock;

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LATENCY(L)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .r0_req   (r0_req),
    .r0_we    (r0_we),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_done  (r0_done),
    .r0_rdata (r0_rdata),
    .r1_req   (r1_req),
    .r1_we    (r1_we),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_done  (r1_done),
    .r1_rdata (r1_rdata),
    .mem_write(mem_write),
    .mem_read (mem_read),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
`ifdef ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
    .stat_contend(stat_contend)
`endif
  );

  // data_mem stand-in: 16 words (low address nibble), registered read with L-stage delay.
  // Outside a read the output is random so a mistimed capture is visible.
  logic [15:0] dm [16] = '{default: 16'h0000};
  logic [15:0] pipe [L];
  always @(posedge clock) begin
    if (mem_write) dm[mem_addr[3:0]] <= mem_wdata;
    pipe[0] <= mem_read ? dm[mem_addr[3:0]] : 16'($urandom);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[L-1];

  // Requester drive values
  logic        req_d [2];
  logic        we_d [2];
  logic [15:0] addr_d [2];
  logic [15:0] wdata_d [2];
  bit          pending [2];
  assign r0_req = req_d[0];  assign r0_we = we_d[0];
  assign r0_addr = addr_d[0]; assign r0_wdata = wdata_d[0];
  assign r1_req = req_d[1];  assign r1_we = we_d[1];
  assign r1_addr = addr_d[1]; assign r1_wdata = wdata_d[1];

  // Reference model state
  int          k;          // rising edges seen
  int          free_at;    // first edge at which a new request may be sampled
  int          done_edge;
  bit          m_act, m_we, last_grant;
  int          m_who;
  logic [15:0] m_addr, m_wdata;
  logic [15:0] m_rdata [2];
  logic [15:0] ref_mem [16] = '{default: 16'h0000};
  int          g_cnt [2];
  int          c_cnt;
  bit          e_done [2];
  bit          e_wr, e_rd, e_busy;

  int errors = 0;
  int checks = 0;

  typedef struct {int who; bit we; logic [15:0] addr; logic [15:0] wdata;} op_t;
  op_t dir_ops [5];
  int  dir_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    m_act = 0; last_grant = 1; free_at = 0;
    m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    g_cnt[0] = 0; g_cnt[1] = 0; c_cnt = 0;
    e_done[0] = 0; e_done[1] = 0;
  endtask

  // Predict outputs after rising edge k from the requests presented at that edge.
  task automatic model_step();
    int w;
    e_done[0] = 0; e_done[1] = 0; e_wr = 0; e_rd = 0;
    if (!m_act && k >= free_at && (req_d[0] || req_d[1])) begin
      if (req_d[0] && req_d[1]) begin
        w = last_grant ? 0 : 1;
        c_cnt++;
      end else begin
        w = req_d[1] ? 1 : 0;
      end
      g_cnt[w]++;
      last_grant = (w == 1);
      m_act = 1; m_who = w; m_we = we_d[w]; m_addr = addr_d[w]; m_wdata = wdata_d[w];
      done_edge = k + 1 + (m_we ? 0 : L);
      e_wr = m_we; e_rd = !m_we;
      if (m_we) ref_mem[m_addr[3:0]] = m_wdata;
    end else if (m_act && k == done_edge) begin
      e_done[m_who] = 1;
      if (!m_we) m_rdata[m_who] = ref_mem[m_addr[3:0]];
      m_act = 0;
      free_at = k + 2;
    end
    e_busy = m_act || e_done[0] || e_done[1];
  endtask

  task automatic compare_outputs();
    check("r0_done", 32'(r0_done), 32'(e_done[0]));
    check("r1_done", 32'(r1_done), 32'(e_done[1]));
    check("r0_rdata", 32'(r0_rdata), 32'(m_rdata[0]));
    check("r1_rdata", 32'(r1_rdata), 32'(m_rdata[1]));
    check("mem_write", 32'(mem_write), 32'(e_wr));
    check("mem_read", 32'(mem_read), 32'(e_rd));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic raise(input int i, input bit we, input logic [15:0] a, input logic [15:0] d);
    req_d[i] = 1; we_d[i] = we; addr_d[i] = a; wdata_d[i] = d; pending[i] = 1;
  endtask

  // mode 0: random, 1: continuous contention, 2: no new requests, 3: directed list
  task automatic drive(input int mode);
    for (int i = 0; i < 2; i++) begin
      if (e_done[i]) begin
        // In random mode a requester sometimes keeps req high to re-issue the same op.
        if (!(mode == 0 && $urandom_range(0, 3) == 0)) begin
          req_d[i] = 0; pending[i] = 0;
        end
      end else if (!pending[i]) begin
        if (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0)) begin
          raise(i, 1'($urandom_range(0, 1)), 16'h1110 + 16'($urandom_range(0, 15)),
                16'($urandom));
        end
      end
    end
    if (mode == 3 && !pending[0] && !pending[1] && dir_idx < 5) begin
      raise(dir_ops[dir_idx].who, dir_ops[dir_idx].we, dir_ops[dir_idx].addr,
            dir_ops[dir_idx].wdata);
      dir_idx++;
    end
  endtask

  task automatic run(input int n, input int mode);
    repeat (n) begin
      @(negedge clock);
      k++;
      model_step();
      compare_outputs();
      drive(mode);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_d[i] = 0; we_d[i] = 0; addr_d[i] = '0; wdata_d[i] = '0; pending[i] = 0;
    end
    k = 0;
    model_reset();
    dir_ops[0] = '{who: 0, we: 1'b1, addr: 16'h1111, wdata: 16'h0001};
    dir_ops[1] = '{who: 0, we: 1'b0, addr: 16'h1111, wdata: 16'h0000};
    dir_ops[2] = '{who: 1, we: 1'b1, addr: 16'h0002, wdata: 16'hBEEF};
    dir_ops[3] = '{who: 0, we: 1'b0, addr: 16'h1111, wdata: 16'h0000};
    dir_ops[4] = '{who: 1, we: 1'b0, addr: 16'h0002, wdata: 16'h0000};
    dir_idx = 0;

    // Reset state
    @(negedge clock);
    k++;
    compare_outputs();
    reset_n = 1'b1;

    run(40, 3);   // directed write, readback, write isolation
    run(60, 1);   // continuous contention
    run(400, 0);  // random traffic
    run(20, 2);   // drain

`ifdef ARB_STATS_EN
    check("stat_grant0", 32'(stat_grant0), 32'(g_cnt[0]));
    check("stat_grant1", 32'(stat_grant1), 32'(g_cnt[1]));
    check("stat_contend", 32'(stat_contend), 32'(c_cnt));
    stat_clr = 1'b1;
    @(negedge clock);
    k++;
    stat_clr = 1'b0;
    check("stat_clr_g0", 32'(stat_grant0), 32'h0);
    check("stat_clr_g1", 32'(stat_grant1), 32'h0);
    check("stat_clr_c", 32'(stat_contend), 32'h0);
`endif

    // Reset in the middle of a read (in WAIT)
    raise(0, 1'b0, 16'h1111, 16'h0000);
    run(2, 2);    // grant edge, then ISSUE -> WAIT edge
    check("pre_rst_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rst_mem_read", 32'(mem_read), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_r0_done", 32'(r0_done), 32'h0);
    check("rst_r1_done", 32'(r1_done), 32'h0);
    check("rst_r0_rdata", 32'(r0_rdata), 32'h0);
    req_d[0] = 0; pending[0] = 0;
    model_reset();
    @(negedge clock);
    k++;
    reset_n = 1'b1;
    run(10, 2);   // no done pulse for the dropped read
    run(150, 0);  // arbitration restarts with requester 0 favoured
    run(20, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
